// File: rtl/spi_slave_fe_p_if.sv
// Pin-side and parallel-side signals of the SPI slave front end.
// The slave modport is the front end's own view; master is the surrounding logic / bench.
interface spi_slave_fe_p_if #(
   parameter int DATA_W = 8
);
   logic              sclk;
   logic              ss;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic              cpol;
   logic              cpha;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              rx_overrun;
   logic              busy;

   modport slave (
      input  sclk, ss, mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
   );

   modport master (
      output sclk, ss, mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
   );
endinterface

// File: rtl/spi_slave_fe_p.sv
// Parametrised SPI slave front end. Every SPI pin is oversampled in the clk
// domain; edges of sclk are found by comparing the synchronised value with a
// one-cycle history flop. Supports all four SPI modes, either bit order, and
// valid/ready handshakes on the tx and rx words.
module spi_slave_fe_p #(
   parameter int               DATA_W      = 8,
   parameter bit               MSB_FIRST   = 1'b1,
   parameter int               SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] DUMMY      = '0
) (
   input logic             clk,
   input logic             rst,
   spi_slave_fe_p_if.slave bus
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t              state, state_n;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                sclk_hist, ss_hist;
   logic                mode_cpol, mode_cpha;
   logic [CNT_W-1:0]    bit_cnt;
   logic                done_p1;
   logic                miso_reg;
   logic [DATA_W-1:0]   tx_sh, rx_sh, hold_data;
   logic                hold_full;
   logic                rx_valid_r, rx_overrun_r;
   logic [DATA_W-1:0]   rx_data_r;

   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic sample_edge, shift_edge, ss_fall, ss_rise;
   logic word_start, shift_act, tx_accept;
   logic [DATA_W-1:0] load_word;

   // Bit that goes on the wire first from a word.
   function automatic logic head_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // Drop the bit just transmitted.
   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   // Append a received bit so that the word ends up in natural bit order.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
   endfunction

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign ss_s        = ss_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_hist;
   assign sclk_fall   = ~sclk_s & sclk_hist;
   assign lead_edge   = mode_cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = mode_cpol ? sclk_rise : sclk_fall;
   assign sample_edge = mode_cpha ? trail_edge : lead_edge;
   assign shift_edge  = mode_cpha ? lead_edge : trail_edge;
   assign ss_fall     = ~ss_s & ss_hist;
   assign ss_rise     = ss_s & ~ss_hist;
   assign shift_act   = (state == SHIFT) && !ss_rise;
   assign tx_accept   = bus.tx_valid && !hold_full;
   assign load_word   = hold_full ? hold_data : DUMMY;

   // Input synchronisers plus edge-history flops; reset to an idle, deselected bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_hist <= 1'b0;
         ss_hist   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         sclk_hist <= sclk_s;
         ss_hist   <= ss_s;
      end
   end

   // Mode follows the pins while deselected and is frozen for the whole frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_cpol <= 1'b0;
         mode_cpha <= 1'b0;
      end else if (ss_s) begin
         mode_cpol <= bus.cpol;
         mode_cpha <= bus.cpha;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // FSM next state; word_start marks the cycle a tx word enters the shifter.
   always_comb begin
      state_n    = state;
      word_start = 1'b0;
      case (state)
         IDLE:  if (ss_fall) state_n = LOAD;
         LOAD:  begin
            word_start = 1'b1;
            state_n    = SHIFT;
         end
         SHIFT: if (done_p1) word_start = 1'b1;
         default: state_n = IDLE;
      endcase
      if (ss_rise) begin
         state_n    = IDLE;
         word_start = 1'b0;
      end
   end

   // Bit counter, word-complete strobe and the miso output flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= CNT_LAST;
         done_p1  <= 1'b0;
         miso_reg <= 1'b0;
      end else begin
         done_p1 <= 1'b0;
         if (shift_act && !done_p1) begin
            if (sample_edge) begin
               if (bit_cnt == '0) done_p1 <= 1'b1;
               else               bit_cnt <= bit_cnt - 1'b1;
            end
         end else begin
            bit_cnt <= CNT_LAST;
         end
         if (word_start && state == LOAD && !mode_cpha)
            miso_reg <= head_bit(load_word);
         else if (shift_act && shift_edge)
            miso_reg <= head_bit(tx_sh);
      end
   end

   // Shift registers and tx holding data. In cpha=0 the first bit is already
   // on miso after LOAD, so the shifter starts one bit ahead.
   always_ff @(posedge clk) begin
      if (word_start)
         tx_sh <= (state == LOAD && !mode_cpha) ? shift_out(load_word) : load_word;
      else if (shift_act && shift_edge)
         tx_sh <= shift_out(tx_sh);
      if (shift_act && sample_edge)
         rx_sh <= shift_in(rx_sh, mosi_s);
      if (tx_accept)
         hold_data <= bus.tx_data;
   end

   // Tx holding register occupancy: filled by the handshake, emptied at each word start.
   always_ff @(posedge clk) begin
      if (rst)             hold_full <= 1'b0;
      else if (tx_accept)  hold_full <= 1'b1;
      else if (word_start) hold_full <= 1'b0;
   end

   // Rx word register, valid flag and overrun pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_r    <= '0;
         rx_valid_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
      end else if (done_p1) begin
         rx_data_r    <= rx_sh;
         rx_valid_r   <= 1'b1;
         rx_overrun_r <= rx_valid_r && !bus.rx_ready;
      end else begin
         rx_overrun_r <= 1'b0;
         if (rx_valid_r && bus.rx_ready) rx_valid_r <= 1'b0;
      end
   end

   assign bus.miso_oe    = ~ss_s;
   assign bus.miso       = miso_reg & ~ss_s;
   assign bus.tx_ready   = ~hold_full;
   assign bus.rx_data    = rx_data_r;
   assign bus.rx_valid   = rx_valid_r;
   assign bus.rx_overrun = rx_overrun_r;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_fe_p.sv
// Bench for spi_slave_fe_p: an 8-bit MSB-first instance (DUMMY=0xFF) and a
// 16-bit LSB-first instance share sclk/mosi/mode pins but have separate ss.
// Expected rx words are queued when a frame is driven and compared when the
// front end hands the word over.
module tb_spi_slave_fe_p;
   localparam int H = 6;   // sclk half period in clk cycles

   logic clk, rst;
   logic sclk, mosi, cpol, cpha, ss8, ss16;
   logic m_cpol, m_cpha;
   int   n_checks, n_errors;
   int   ovr8;
   logic [31:0] rxq8[$];
   logic [31:0] rxq16[$];

   spi_slave_fe_p_if #(.DATA_W(8))  if8 ();
   spi_slave_fe_p_if #(.DATA_W(16)) if16 ();

   assign if8.sclk  = sclk;
   assign if8.mosi  = mosi;
   assign if8.cpol  = cpol;
   assign if8.cpha  = cpha;
   assign if8.ss    = ss8;
   assign if16.sclk = sclk;
   assign if16.mosi = mosi;
   assign if16.cpol = cpol;
   assign if16.cpha = cpha;
   assign if16.ss   = ss16;

   spi_slave_fe_p #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2), .DUMMY(8'hFF)) dut8 (
      .clk(clk), .rst(rst), .bus(if8)
   );
   spi_slave_fe_p #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(2), .DUMMY(16'h0000)) dut16 (
      .clk(clk), .rst(rst), .bus(if16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare each accepted rx word against the queue head.
   always @(negedge clk) begin
      if (!rst && if8.rx_valid && if8.rx_ready) begin
         check("rx8_expected", rxq8.size() > 0, 1);
         if (rxq8.size() > 0) check("rx8_data", if8.rx_data, rxq8.pop_front());
      end
      if (!rst && if16.rx_valid && if16.rx_ready) begin
         check("rx16_expected", rxq16.size() > 0, 1);
         if (rxq16.size() > 0) check("rx16_data", if16.rx_data, rxq16.pop_front());
      end
   end

   always @(posedge clk) if (if8.rx_overrun) ovr8++;

   task automatic check_reset(input string tag, input int sel);
      if (sel == 0) begin
         check({tag, "_miso8"},    if8.miso, 0);
         check({tag, "_oe8"},      if8.miso_oe, 0);
         check({tag, "_txrdy8"},   if8.tx_ready, 1);
         check({tag, "_rxv8"},     if8.rx_valid, 0);
         check({tag, "_rxd8"},     if8.rx_data, 0);
         check({tag, "_ovr8"},     if8.rx_overrun, 0);
         check({tag, "_busy8"},    if8.busy, 0);
      end else begin
         check({tag, "_miso16"},   if16.miso, 0);
         check({tag, "_oe16"},     if16.miso_oe, 0);
         check({tag, "_txrdy16"},  if16.tx_ready, 1);
         check({tag, "_rxv16"},    if16.rx_valid, 0);
         check({tag, "_rxd16"},    if16.rx_data, 0);
         check({tag, "_ovr16"},    if16.rx_overrun, 0);
         check({tag, "_busy16"},   if16.busy, 0);
      end
   endtask

   task automatic set_mode(input logic c, input logic h);
      m_cpol = c; m_cpha = h;
      cpol = c;   cpha = h;
      sclk = c;
      repeat (10) @(negedge clk);
   endtask

   task automatic load_tx(input int sel, input logic [31:0] d);
      int k;
      for (k = 0; k < 100; k++) begin
         if ((sel == 0 ? if8.tx_ready : if16.tx_ready) == 1'b1) break;
         @(negedge clk);
      end
      check("tx_ready_wait", k < 100, 1);
      if (sel == 0) begin if8.tx_data = d[7:0];   if8.tx_valid = 1'b1; end
      else          begin if16.tx_data = d[15:0]; if16.tx_valid = 1'b1; end
      @(negedge clk);
      if8.tx_valid = 1'b0;
      if16.tx_valid = 1'b0;
   endtask

   task automatic frame_begin(input int sel);
      if (sel == 0) ss8 = 1'b0; else ss16 = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame_end(input int sel);
      repeat (H) @(negedge clk);
      cpol = m_cpol;
      if (sel == 0) ss8 = 1'b1; else ss16 = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // Master side of one word: drive mosi, toggle sclk, capture miso on the master's sample edge.
   task automatic spi_word(input int sel, input int nbits, input bit msb,
                           input logic [31:0] mo, output logic [31:0] mi);
      logic b, m;
      mi = '0;
      m  = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         b = msb ? mo[nbits-1-i] : mo[i];
         if (!m_cpha) mosi = b;
         repeat (H) @(negedge clk);
         if (!m_cpha) m = (sel == 0) ? if8.miso : if16.miso;
         sclk = ~m_cpol;
         if (m_cpha) mosi = b;
         repeat (H) @(negedge clk);
         if (m_cpha) m = (sel == 0) ? if8.miso : if16.miso;
         sclk = m_cpol;
         if (msb) mi = {mi[30:0], m};
         else     mi[i] = m;
      end
   endtask

   task automatic wait_drain(input int sel);
      int k;
      for (k = 0; k < 80; k++) begin
         if (sel == 0 && rxq8.size() == 0 && !if8.rx_valid) break;
         if (sel == 1 && rxq16.size() == 0 && !if16.rx_valid) break;
         @(negedge clk);
      end
      check("rx_drain", k < 80, 1);
   endtask

   initial begin
      logic [31:0] mi;
      int ovr_snap;
      n_checks = 0; n_errors = 0;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
      m_cpol = 1'b0; m_cpha = 1'b0; ss8 = 1'b1; ss16 = 1'b1;
      if8.tx_data = '0;  if8.tx_valid = 1'b0;  if8.rx_ready = 1'b1;
      if16.tx_data = '0; if16.tx_valid = 1'b0; if16.rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      check_reset("rst", 0);
      check_reset("rst", 1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Mode 0 basic word
      set_mode(1'b0, 1'b0);
      load_tx(0, 32'hA5);
      check("tx_ready_drop", if8.tx_ready, 0);
      frame_begin(0);
      check("busy_in_frame", if8.busy, 1);
      check("oe_in_frame", if8.miso_oe, 1);
      check("tx_ready_after_load", if8.tx_ready, 1);
      rxq8.push_back(32'h3C);
      spi_word(0, 8, 1'b1, 32'h3C, mi);
      check("m0_miso", mi, 32'hA5);
      frame_end(0);
      wait_drain(0);

      // Modes 1..3; in mode 2 the cpol pin flips mid-frame and must be ignored
      for (int m = 1; m < 4; m++) begin
         set_mode(m[1], m[0]);
         load_tx(0, 32'h69);
         frame_begin(0);
         if (m == 2) cpol = ~m_cpol;
         rxq8.push_back(32'h96);
         spi_word(0, 8, 1'b1, 32'h96, mi);
         check($sformatf("mode%0d_miso", m), mi, 32'h69);
         frame_end(0);
         wait_drain(0);
      end

      // Nothing buffered: DUMMY goes out
      set_mode(1'b0, 1'b0);
      frame_begin(0);
      rxq8.push_back(32'h5A);
      spi_word(0, 8, 1'b1, 32'h5A, mi);
      check("dummy_miso", mi, 32'hFF);
      frame_end(0);
      wait_drain(0);

      // Back-to-back words with rx_ready low -> one overrun
      if8.rx_ready = 1'b0;
      load_tx(0, 32'hC6);
      ovr_snap = ovr8;
      frame_begin(0);
      spi_word(0, 8, 1'b1, 32'h11, mi);
      check("b2b_miso0", mi, 32'hC6);
      spi_word(0, 8, 1'b1, 32'h22, mi);
      check("b2b_miso1", mi, 32'hFF);
      frame_end(0);
      check("overrun_count", ovr8 - ovr_snap, 1);
      check("ovr_rx_valid", if8.rx_valid, 1);
      check("ovr_rx_data", if8.rx_data, 32'h22);
      rxq8.push_back(32'h22);
      if8.rx_ready = 1'b1;
      wait_drain(0);

      // Aborted word after 5 bits, then a full word
      load_tx(0, 32'h55);
      frame_begin(0);
      spi_word(0, 5, 1'b1, 32'h18, mi);
      check("partial_miso", mi, 32'h0A);
      frame_end(0);
      check("partial_busy", if8.busy, 0);
      check("partial_rx_valid", if8.rx_valid, 0);
      load_tx(0, 32'hC3);
      frame_begin(0);
      rxq8.push_back(32'h81);
      spi_word(0, 8, 1'b1, 32'h81, mi);
      check("after_abort_miso", mi, 32'hC3);
      frame_end(0);
      wait_drain(0);

      // 16-bit LSB-first instance
      load_tx(1, 32'h1234);
      frame_begin(1);
      rxq16.push_back(32'h1234);
      spi_word(1, 16, 1'b0, 32'h1234, mi);
      check("lsb_first_bit", mi[0], 1'b0);
      check("lsb_miso16", mi, 32'h1234);
      frame_end(1);
      wait_drain(1);

      // Reset in the middle of a word, with a word waiting in the holding register
      load_tx(1, 32'hBEEF);
      frame_begin(1);
      load_tx(1, 32'h7777);
      check("hold_full16", if16.tx_ready, 0);
      spi_word(1, 7, 1'b0, 32'h0055, mi);
      sclk = ~m_cpol;
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst", 1);
      rst = 1'b0;
      ss16 = 1'b1;
      sclk = m_cpol;
      repeat (10) @(negedge clk);

      check("rxq8_empty", rxq8.size(), 0);
      check("rxq16_empty", rxq16.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got 0x0, expected 0x1");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/spi_slave_fe_p.md
Name: spi_slave_fe_p

Overview:
Parametrised SPI slave front end. Successor to the fixed 8-bit, mode-0-only front end: configurable word width, all four SPI modes, selectable bit order, and valid/ready handshakes on both parallel directions. All SPI pins are oversampled in the system clock domain; no logic is clocked by sclk. Sits between the chip pins and the register bank / host-command decoder.

Parameters:
DATA_W, 8, word width in bits (4..32)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on sclk, ss and mosi (>=2)
DUMMY, 0, word transmitted when no tx word is buffered (DATA_W bits)

Ports:
clk  in  1  system clock; must be >= 4x the sclk frequency
rst  in  1  synchronous reset, active-high
sclk  in  1  SPI serial clock (asynchronous)
ss  in  1  slave select, active low (asynchronous)
mosi  in  1  master out, slave in
miso  out  1  master in, slave out
miso_oe  out  1  miso output enable (= synchronised ss low)
cpol  in  1  clock polarity; sampled only while ss is high
cpha  in  1  clock phase; sampled only while ss is high
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx holding register empty
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid; held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  one-cycle pulse: a word was completed while rx_valid was still high
busy  out  1  transfer in progress (state != IDLE)

Behaviour:
- Reset (clk edge with rst=1): state IDLE; miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, busy=0; synchronisers cleared to sclk=cpol-neutral 0, ss=1. Reset mid-transfer aborts immediately; the buffered tx word is lost.
- Synchronisation: SYNC_STAGES flops per input, plus one history flop on sclk. An edge is detected when the last synchroniser stage differs from the history flop. Detection latency is SYNC_STAGES+1 clk cycles.
- Mode latch: {cpol,cpha} is registered every cycle while synchronised ss=1 and frozen while ss=0.
  - leading edge = rising when cpol=0, falling when cpol=1.
  - cpha=0: sample mosi on leading edge, shift miso on trailing edge.
  - cpha=1: shift miso on leading edge, sample mosi on trailing edge.
- Tx holding register:
  - tx_valid && tx_ready loads it and drops tx_ready on the next cycle.
  - It is moved into the shift register at each word start; tx_ready returns high on that cycle.
  - If it is empty at a word start, DUMMY is shifted instead.
- FSM:
  - IDLE -> LOAD on synchronised ss falling.
  - LOAD (1 cycle): load the shift register, bit_cnt = DATA_W-1. miso = first bit when cpha=0; miso is held unchanged when cpha=1. -> SHIFT.
  - SHIFT:
    - Each sample edge shifts the synchronised mosi into the rx shifter.
    - Each shift edge drives the next tx bit on miso. The cpha=1 first leading edge drives bit 0 of the sequence.
    - After the sample edge with bit_cnt=0: on the next cycle rx_data <= the assembled word, rx_valid=1, bit_cnt reloads, and the next tx word is loaded (back-to-back words with no ss toggle).
  - Any state -> IDLE on synchronised ss rising. A partial word is discarded: no rx_valid, and the tx word in the shift register counts as consumed.
- Bit order: when MSB_FIRST=0, both directions shift LSB first.
- rx handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - If a word completes while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, rx_overrun pulses for 1 cycle.
  - If a word completes in the same cycle as an accept: no overrun, and rx_valid stays 1 with the new data.
- miso is 0 whenever miso_oe=0.

Test Plan:
- Mode 0, DATA_W=8, tx 0xA5 loaded before ss falls; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready high one cycle after LOAD.
- Sweep modes 1/2/3 with master 0x96 / slave 0x69 -> both sides exact every mode; cpol toggled while ss low has no effect.
- No tx word buffered, DUMMY=0xFF -> miso outputs 0xFF; rx unaffected.
- Two back-to-back words 0x11, 0x22 with rx_ready held 0 -> rx_overrun pulses once, rx_data=0x22, rx_valid=1.
- ss raised after 5 bits -> no rx_valid, busy=0, bit counter reset; next full word 0x81 received correctly.
- DATA_W=16, MSB_FIRST=0, mode 0, word 0x1234 -> first miso bit = bit0 of 0x1234; rx_data=0x1234. Assert rst mid-word -> all outputs at reset values next cycle.
